// File: rtl/rh_mbdma_pkg.sv
// Shared types and defaults for the RH11 Massbus data channel.
package rh_mbdma_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_BUSREQ,
        S_WAIT,
        S_ACK,
        S_ERR
    } state_e;

    typedef logic [17:0] ba_t;
    typedef logic [15:0] wc_t;

    localparam int unsigned TIMEOUT_DEF = 127;
    localparam int unsigned BAINC_DEF   = 4;
    localparam int unsigned WCINC_DEF   = 2;

endpackage

// File: rtl/rh_mbdma_tmo.sv
// Bus-acknowledge watchdog: cleared at the start of each NPR cycle, counts while
// waiting and saturates once the limit is reached.
module rh_mbdma_tmo
    import rh_mbdma_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic done_o
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !done_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == CW'(TIMEOUT));

endmodule

// File: rtl/rh_mbdma.sv
// RH11-side Massbus data channel: turns each device word request into one KS10
// NPR cycle, maintaining the BA/WC registers and a sticky NXM flag.
module rh_mbdma
    import rh_mbdma_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF,
    parameter int unsigned BAINC   = BAINC_DEF,
    parameter int unsigned WCINC   = WCINC_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        baLOAD,
    input  logic [17:0] baDATA,
    input  logic        wcLOAD,
    input  logic [15:0] wcDATA,
    input  logic        devREQ,
    input  logic        devNPRO,
    input  logic [35:0] devDATAO,
    output logic        devACK,
    output logic [35:0] devDATAI,
    output logic        devWCZ,
    output logic        busREQ,
    output logic        busWRITE,
    output logic [17:0] busADDR,
    output logic [35:0] busDATAO,
    input  logic        busACK,
    input  logic [35:0] busDATAI,
    output logic [17:0] rhBA,
    output logic [15:0] rhWC,
    output logic        rhNXM,
    output logic        busy
);

    state_e      state_q;
    ba_t         ba_q;
    wc_t         wc_q;
    logic        nxm_q;
    logic        npro_q;
    logic [35:0] wdata_q;
    logic [35:0] rdata_q;
    logic        busreq_q;
    logic        devack_q;

    logic        tmo_clr;
    logic        tmo_en;
    logic        tmo_done;

    assign tmo_clr = clr || (state_q == S_BUSREQ);
    assign tmo_en  = (state_q == S_WAIT) && !busACK;

    rh_mbdma_tmo #(
        .TIMEOUT (TIMEOUT)
    ) u_tmo (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (tmo_clr),
        .en_i   (tmo_en),
        .done_o (tmo_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            ba_q     <= '0;
            wc_q     <= '0;
            nxm_q    <= 1'b0;
            npro_q   <= 1'b0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            busreq_q <= 1'b0;
            devack_q <= 1'b0;
        end else if (clr) begin
            // Controller clear overrides any ack or load sampled on the same edge.
            state_q  <= S_IDLE;
            ba_q     <= '0;
            wc_q     <= '0;
            nxm_q    <= 1'b0;
            npro_q   <= 1'b0;
            wdata_q  <= '0;
            busreq_q <= 1'b0;
            devack_q <= 1'b0;
        end else begin
            devack_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (baLOAD) begin
                        ba_q <= baDATA;
                    end
                    if (wcLOAD) begin
                        wc_q <= wcDATA;
                    end
                    if (devREQ && !devWCZ && !nxm_q) begin
                        npro_q   <= devNPRO;
                        wdata_q  <= devDATAO;
                        busreq_q <= 1'b1;
                        state_q  <= S_BUSREQ;
                    end
                end
                S_BUSREQ: begin
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    // An ack arriving on the timeout cycle still completes normally.
                    if (busACK) begin
                        rdata_q  <= busDATAI;
                        ba_q     <= ba_q + ba_t'(BAINC);
                        wc_q     <= wc_q + wc_t'(WCINC);
                        busreq_q <= 1'b0;
                        devack_q <= 1'b1;
                        state_q  <= S_ACK;
                    end else if (tmo_done) begin
                        nxm_q    <= 1'b1;
                        busreq_q <= 1'b0;
                        state_q  <= S_ERR;
                    end
                end
                S_ACK: begin
                    state_q <= S_IDLE;
                end
                S_ERR: begin
                    state_q <= S_ERR;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign devACK   = devack_q;
    assign devDATAI = rdata_q;
    assign devWCZ   = (wc_q == '0);
    assign busREQ   = busreq_q;
    assign busWRITE = npro_q;
    assign busADDR  = ba_q;
    assign busDATAO = wdata_q;
    assign rhBA     = ba_q;
    assign rhWC     = wc_q;
    assign rhNXM    = nxm_q;
    assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_rh_mbdma.sv
// Directed and randomized bench for rh_mbdma, checked against a transfer-level model
// of the BA/WC/NXM registers and the request/ack handshake timing.
module tb_rh_mbdma;

    localparam int unsigned TMO   = 127;
    localparam int unsigned BAINC = 4;
    localparam int unsigned WCINC = 2;

    logic        clk;
    logic        rst_n;
    logic        clr;
    logic        baLOAD;
    logic [17:0] baDATA;
    logic        wcLOAD;
    logic [15:0] wcDATA;
    logic        devREQ;
    logic        devNPRO;
    logic [35:0] devDATAO;
    logic        devACK;
    logic [35:0] devDATAI;
    logic        devWCZ;
    logic        busREQ;
    logic        busWRITE;
    logic [17:0] busADDR;
    logic [35:0] busDATAO;
    logic        busACK;
    logic [35:0] busDATAI;
    logic [17:0] rhBA;
    logic [15:0] rhWC;
    logic        rhNXM;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    logic [17:0] m_ba;
    logic [15:0] m_wc;

    rh_mbdma #(
        .TIMEOUT (TMO),
        .BAINC   (BAINC),
        .WCINC   (WCINC)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .baLOAD   (baLOAD),
        .baDATA   (baDATA),
        .wcLOAD   (wcLOAD),
        .wcDATA   (wcDATA),
        .devREQ   (devREQ),
        .devNPRO  (devNPRO),
        .devDATAO (devDATAO),
        .devACK   (devACK),
        .devDATAI (devDATAI),
        .devWCZ   (devWCZ),
        .busREQ   (busREQ),
        .busWRITE (busWRITE),
        .busADDR  (busADDR),
        .busDATAO (busDATAO),
        .busACK   (busACK),
        .busDATAI (busDATAI),
        .rhBA     (rhBA),
        .rhWC     (rhWC),
        .rhNXM    (rhNXM),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [35:0] rnd36();
        return {4'($urandom), 32'($urandom)};
    endfunction

    task automatic load(input logic [17:0] b, input logic [15:0] w);
        baLOAD = 1'b1; baDATA = b;
        wcLOAD = 1'b1; wcDATA = w;
        @(negedge clk);
        baLOAD = 1'b0; wcLOAD = 1'b0;
        m_ba = b; m_wc = w;
        chk("load_ba", rhBA, m_ba);
        chk("load_wc", rhWC, m_wc);
    endtask

    task automatic do_clr();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        m_ba = '0; m_wc = '0;
        chk("clr_busy", busy, 0);
        chk("clr_nxm", rhNXM, 0);
        chk("clr_ba", rhBA, 0);
        chk("clr_wc", rhWC, 0);
    endtask

    // One complete transfer starting and ending at a negedge in IDLE.
    task automatic xfer(input logic npro, input logic [35:0] wd, input logic [35:0] rd,
                        input int unsigned dly, input bit ld_req, input logic [17:0] ld_val,
                        input bit ld_busy);
        bit held;
        devREQ = 1'b1; devNPRO = npro; devDATAO = wd;
        if (ld_req) begin
            baLOAD = 1'b1; baDATA = ld_val; m_ba = ld_val;
        end
        @(negedge clk);
        baLOAD = 1'b0;
        chk("req_busREQ", busREQ, 1);
        chk("req_addr", busADDR, m_ba);
        chk("req_write", busWRITE, npro);
        if (npro) chk("req_wdata", busDATAO, wd);
        held = 1'b1;
        for (int i = 0; i < int'(dly); i++) begin
            @(negedge clk);
            held &= (busREQ === 1'b1) && (devACK === 1'b0) && (busADDR === m_ba);
            if (ld_busy && i == 0) begin
                baLOAD = 1'b1; baDATA = ~m_ba;
                wcLOAD = 1'b1; wcDATA = ~m_wc;
            end else begin
                baLOAD = 1'b0; wcLOAD = 1'b0;
            end
        end
        chk("wait_hold", held, 1);
        busACK = 1'b1; busDATAI = rd;
        @(negedge clk);
        busACK = 1'b0; baLOAD = 1'b0; wcLOAD = 1'b0; devREQ = 1'b0;
        m_ba = m_ba + 18'(BAINC);
        m_wc = m_wc + 16'(WCINC);
        chk("ack_devACK", devACK, 1);
        if (!npro) chk("ack_devDATAI", devDATAI, rd);
        chk("ack_ba", rhBA, m_ba);
        chk("ack_wc", rhWC, m_wc);
        chk("ack_wcz", devWCZ, (m_wc == 16'h0));
        chk("ack_busREQ", busREQ, 0);
        @(negedge clk);
        chk("post_devACK", devACK, 0);
        chk("post_busy", busy, 0);
    endtask

    initial begin
        bit ok;
        logic [15:0] w;
        rst_n = 1'b0; clr = 1'b0;
        baLOAD = 1'b0; baDATA = '0; wcLOAD = 1'b0; wcDATA = '0;
        devREQ = 1'b0; devNPRO = 1'b0; devDATAO = '0;
        busACK = 1'b0; busDATAI = '0;
        m_ba = '0; m_wc = '0;
        repeat (2) @(negedge clk);
        chk("rst_devACK", devACK, 0);
        chk("rst_devDATAI", devDATAI, 0);
        chk("rst_wcz", devWCZ, 1);
        chk("rst_busREQ", busREQ, 0);
        chk("rst_busWRITE", busWRITE, 0);
        chk("rst_busADDR", busADDR, 0);
        chk("rst_busDATAO", busDATAO, 0);
        chk("rst_ba", rhBA, 0);
        chk("rst_wc", rhWC, 0);
        chk("rst_nxm", rhNXM, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // T1/T2: device writes to memory, WC runs out after two words.
        load(18'o1000, 16'hFFFC);
        xfer(1'b1, rnd36(), rnd36(), 3, 1'b0, '0, 1'b0);
        chk("t1_ba", rhBA, 18'o1004);
        chk("t1_wc", rhWC, 16'hFFFE);
        xfer(1'b1, rnd36(), rnd36(), 2, 1'b0, '0, 1'b0);
        chk("t2_wcz", devWCZ, 1);
        devREQ = 1'b1;
        ok = 1'b1;
        repeat (4) begin
            @(negedge clk);
            ok &= (busREQ === 1'b0) && (busy === 1'b0);
        end
        devREQ = 1'b0;
        chk("t2_no_service", ok, 1);

        // T3: memory to device read data path.
        load(18'($urandom), 16'hFFF0);
        xfer(1'b0, rnd36(), 36'o123456654321, 2, 1'b0, '0, 1'b0);

        // T4: no acknowledge -> NXM, sticky until clr.
        devREQ = 1'b1; devNPRO = 1'b1; devDATAO = rnd36();
        @(negedge clk);
        chk("tmo_req", busREQ, 1);
        ok = 1'b1;
        for (int k = 0; k <= int'(TMO); k++) begin
            @(negedge clk);
            ok &= (busREQ === 1'b1) && (rhNXM === 1'b0);
        end
        chk("tmo_hold", ok, 1);
        @(negedge clk);
        devREQ = 1'b0;
        chk("tmo_nxm", rhNXM, 1);
        chk("tmo_busREQ", busREQ, 0);
        chk("tmo_busy", busy, 1);
        repeat (3) @(negedge clk);
        chk("err_stay", busy, 1);
        do_clr();

        // Ack arriving on the very cycle the limit is reached still completes.
        load(18'($urandom), 16'h1234);
        xfer(1'b0, rnd36(), rnd36(), TMO + 1, 1'b0, '0, 1'b0);
        chk("edge_nxm", rhNXM, 0);

        // T5: clr coincident with busACK suppresses the ack and the increments.
        load(18'h0ABC0, 16'h0100);
        devREQ = 1'b1; devNPRO = 1'b0;
        @(negedge clk);
        @(negedge clk);
        busACK = 1'b1; busDATAI = rnd36(); clr = 1'b1;
        @(negedge clk);
        busACK = 1'b0; clr = 1'b0; devREQ = 1'b0;
        m_ba = '0; m_wc = '0;
        chk("t5_devACK", devACK, 0);
        chk("t5_ba", rhBA, 0);
        chk("t5_wc", rhWC, 0);
        chk("t5_busy", busy, 0);
        chk("t5_busREQ", busREQ, 0);

        // T6: BA wrap, loads ignored while busy, load coincident with request.
        load(18'h3FFFC, 16'h0010);
        xfer(1'b1, rnd36(), rnd36(), 1, 1'b0, '0, 1'b1);
        chk("t6_wrap", rhBA, 0);
        xfer(1'b0, rnd36(), rnd36(), 2, 1'b1, 18'h15550, 1'b0);

        // Randomized transfers.
        for (int n = 0; n < 24; n++) begin
            if (m_wc == 16'h0 || $urandom_range(0, 3) == 0) begin
                w = 16'($urandom);
                if (w == 16'h0) w = 16'h1;
                load(18'($urandom), w);
            end
            xfer(1'($urandom), rnd36(), rnd36(), $urandom_range(1, 8),
                 ($urandom_range(0, 4) == 0), 18'($urandom), ($urandom_range(0, 4) == 0));
        end

        // Asynchronous reset mid-transfer.
        load(18'h01230, 16'h0040);
        devREQ = 1'b1; devNPRO = 1'b1; devDATAO = rnd36();
        @(negedge clk);
        chk("ar_req", busREQ, 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_busREQ", busREQ, 0);
        chk("ar_busy", busy, 0);
        chk("ar_ba", rhBA, 0);
        chk("ar_wc", rhWC, 0);
        chk("ar_wcz", devWCZ, 1);
        chk("ar_busWRITE", busWRITE, 0);
        chk("ar_busDATAO", busDATAO, 0);
        chk("ar_devACK", devACK, 0);
        @(negedge clk);
        rst_n = 1'b1; devREQ = 1'b0;
        m_ba = '0; m_wc = '0;
        @(negedge clk);
        chk("ar_idle", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
